// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer: sample/hold, binary search via an
// external DAC + comparator, optional 2^n oversampling and round-robin channel scan.
module sar_adc_ctrl #(
  parameter int BITS              = 14,
  parameter int DAC_WIDTH         = 16,
  parameter int SAMPLE_CYCLES     = 2000,
  parameter int HOLD_CYCLES       = 30,
  parameter int DAC_SETTLE_CYCLES = 45,
  parameter int CHANNELS          = 2,
  parameter int AVG_MAX_LOG2      = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic                 continuous_i,
  input  logic                 scan_i,
  input  logic [2:0]           ch_i,
  input  logic [2:0]           avg_log2_i,
  input  logic                 comp_i,
  output logic                 sh_o,
  output logic [2:0]           ch_sel_o,
  output logic [DAC_WIDTH-1:0] dac_data_o,
  output logic                 dac_load_o,
  output logic [BITS-1:0]      data_o,
  output logic [2:0]           data_ch_o,
  output logic                 data_valid_o,
  output logic                 busy_o
);

  localparam int AW    = BITS + AVG_MAX_LOG2;
  localparam int CW    = AVG_MAX_LOG2 + 1;
  localparam int KW    = $clog2(BITS);
  localparam int TMAX0 = (SAMPLE_CYCLES > HOLD_CYCLES) ? SAMPLE_CYCLES : HOLD_CYCLES;
  localparam int TMAX  = (TMAX0 > DAC_SETTLE_CYCLES) ? TMAX0 : DAC_SETTLE_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, HOLD, LOAD, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [KW-1:0]        bit_q, bit_d;
  logic [BITS-1:0]      code_q, code_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           navg_q, navg_d;
  logic                 cont_q, cont_d;
  logic                 scan_q, scan_d;
  logic [2:0]           ch_q, ch_d;
  logic                 sh_q, sh_d;
  logic [DAC_WIDTH-1:0] dac_data_q, dac_data_d;
  logic                 dac_load_q, dac_load_d;
  logic [BITS-1:0]      data_q, data_d;
  logic [2:0]           data_ch_q, data_ch_d;
  logic                 data_valid_q, data_valid_d;
  logic                 busy_q, busy_d;

  logic                 enter_sample;
  logic [BITS-1:0]      code_new;
  logic [CW-1:0]        target;
  logic [2:0]           navg_in;

  function automatic logic [BITS-1:0] trial_code(input logic [BITS-1:0] code,
                                                 input logic [KW-1:0]   k);
    return code | (BITS'(1) << k);
  endfunction

  assign navg_in = (int'(avg_log2_i) > AVG_MAX_LOG2) ? 3'(AVG_MAX_LOG2) : avg_log2_i;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_d        = bit_q;
    code_d       = code_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    navg_d       = navg_q;
    cont_d       = cont_q;
    scan_d       = scan_q;
    ch_d         = ch_q;
    sh_d         = sh_q;
    dac_data_d   = dac_data_q;
    dac_load_d   = 1'b0;
    data_d       = data_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    enter_sample = 1'b0;
    code_new          = code_q;
    code_new[bit_q]   = comp_i;
    target            = CW'(1) << navg_q;

    case (state_q)
      IDLE: begin
        if (start_i || continuous_i) begin
          cont_d       = continuous_i;
          scan_d       = scan_i;
          navg_d       = navg_in;
          ch_d         = ch_i;
          acc_d        = '0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          enter_sample = 1'b1;
        end
      end
      SAMPLE: begin
        if (timer_q == '0) begin
          state_d = HOLD;
          sh_d    = 1'b0;
          timer_d = TW'(HOLD_CYCLES - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      HOLD: begin
        if (timer_q == '0) begin
          state_d    = LOAD;
          dac_data_d = DAC_WIDTH'(trial_code(code_q, bit_q));
          dac_load_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LOAD: begin
        state_d = WAIT;
        timer_d = TW'(DAC_SETTLE_CYCLES - 1);
      end
      WAIT: begin
        if (timer_q == '0) begin
          code_d = code_new;
          // The next trial is launched straight from the freshly decided bit.
          if (bit_q != '0) begin
            bit_d      = bit_q - 1'b1;
            state_d    = LOAD;
            dac_data_d = DAC_WIDTH'(trial_code(code_new, bit_q - 1'b1));
            dac_load_d = 1'b1;
          end else begin
            acc_d   = acc_q + AW'(code_new);
            cnt_d   = cnt_q + 1'b1;
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        if (cnt_q < target) begin
          enter_sample = 1'b1;
        end else begin
          data_d       = BITS'(acc_q >> navg_q);
          data_ch_d    = ch_q;
          data_valid_d = 1'b1;
          if (scan_q) begin
            ch_d = (ch_q >= 3'(CHANNELS - 1)) ? 3'd0 : ch_q + 1'b1;
          end
          if (cont_q && continuous_i) begin
            cont_d       = continuous_i;
            scan_d       = scan_i;
            navg_d       = navg_in;
            acc_d        = '0;
            cnt_d        = '0;
            enter_sample = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sh_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (enter_sample) begin
      state_d = SAMPLE;
      sh_d    = 1'b1;
      timer_d = TW'(SAMPLE_CYCLES - 1);
      code_d  = '0;
      bit_d   = KW'(BITS - 1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_q        <= '0;
      code_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      navg_q       <= '0;
      cont_q       <= 1'b0;
      scan_q       <= 1'b0;
      ch_q         <= '0;
      sh_q         <= 1'b0;
      dac_data_q   <= '0;
      dac_load_q   <= 1'b0;
      data_q       <= '0;
      data_ch_q    <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      code_q       <= code_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      navg_q       <= navg_d;
      cont_q       <= cont_d;
      scan_q       <= scan_d;
      ch_q         <= ch_d;
      sh_q         <= sh_d;
      dac_data_q   <= dac_data_d;
      dac_load_q   <= dac_load_d;
      data_q       <= data_d;
      data_ch_q    <= data_ch_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign sh_o         = sh_q;
  assign ch_sel_o     = ch_q;
  assign dac_data_o   = dac_data_q;
  assign dac_load_o   = dac_load_q;
  assign data_o       = data_q;
  assign data_ch_o    = data_ch_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Parametrised successive-approximation ADC controller for the PmodADC board. It is the next generation of the 14-bit fixed-timing SAR sequencer and adds configurable resolution and timing, single-shot or continuous triggering, multi-channel round-robin scanning, and power-of-two oversampling with averaging. It drives the sample-and-hold and the analog channel mux, and it emits DAC codes plus a load strobe for the existing shift-out DAC interface, which is instantiated beside it at top level. Results go to the audio/streaming logic with a one-cycle valid pulse.

## Interface
- BITS, 14: conversion resolution (2..16).
- DAC_WIDTH, 16: width of dac_data_o; the code is zero-extended to this width (≥ BITS).
- SAMPLE_CYCLES, 2000: number of cycles sh_o is held high (≥1).
- HOLD_CYCLES, 30: number of hold-settle cycles after sh_o falls (≥1).
- DAC_SETTLE_CYCLES, 45: number of wait cycles after each DAC load, before comp_i is sampled (≥1). Must cover the shift-out time.
- CHANNELS, 2: number of analog mux channels (1..8).
- AVG_MAX_LOG2, 4: maximum oversampling exponent.
- clk_i  in  1  clock.
- reset_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start-request pulse; ignored while busy_o=1.
- continuous_i  in  1  1 = free-run, starting the next group immediately after each group.
- scan_i  in  1  1 = advance the channel after each result; 0 = use ch_i.
- ch_i  in  3  fixed channel, used when scan_i=0.
- avg_log2_i  in  3  oversampling exponent n; values above AVG_MAX_LOG2 are clamped.
- comp_i  in  1  comparator output; 1 = input ≥ DAC voltage.
- sh_o  out  1  sample/hold control; 1 = sample.
- ch_sel_o  out  3  analog mux select.
- dac_data_o  out  DAC_WIDTH  current trial code.
- dac_load_o  out  1  one-cycle strobe to the shift-out DAC interface.
- data_o  out  BITS  averaged result.
- data_ch_o  out  3  channel the result belongs to.
- data_valid_o  out  1  one-cycle result strobe.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SAMPLE, HOLD, LOAD, WAIT, DONE.
- IDLE:
  - Leave when start_i=1 or continuous_i=1.
  - On leaving, latch continuous_i, scan_i, avg_log2_i (clamped) and ch_i into the channel register.
  - Clear the accumulator and the conversion counter, then go to SAMPLE.
- SAMPLE: sh_o=1 for SAMPLE_CYCLES cycles. Clear the determined bits and set the bit index k=BITS-1. Then go to HOLD.
- HOLD: sh_o=0 for HOLD_CYCLES cycles, then go to LOAD.
- LOAD (one cycle):
  - dac_data_o = determined | (1<<k), zero-extended to DAC_WIDTH.
  - dac_load_o=1.
  - Then go to WAIT.
- WAIT:
  - Lasts DAC_SETTLE_CYCLES cycles. dac_data_o holds its value.
  - In the last cycle, set determined[k] = comp_i.
  - If k>0: decrement k and go to LOAD.
  - Else: add the completed code to the accumulator, increment the counter, and go to DONE.
- DONE (one cycle):
  - If counter < 2^n: return to SAMPLE on the same channel, with no output.
  - Otherwise:
    - data_o = accumulator >> n. This is a truncating shift and never overflows; the accumulator is BITS+AVG_MAX_LOG2 bits wide.
    - data_ch_o = ch_sel_o and data_valid_o=1.
    - If scan: channel = (channel==CHANNELS-1) ? 0 : channel+1. Else keep channel.
    - If the latched continuous flag is still 1 and continuous_i=1: re-latch the mode inputs, clear the accumulator and counter, and go to SAMPLE.
    - Else go to IDLE.
- ch_sel_o is updated only in IDLE→SAMPLE and DONE. It is stable throughout each conversion.
- Deasserting continuous_i mid-group: the current group completes and is output, then the block goes to IDLE.
- Reset (asynchronous, any state): state=IDLE, and every output is 0 (sh_o, ch_sel_o, dac_data_o, dac_load_o, data_o, data_ch_o, data_valid_o, busy_o). No partial result is output.

## Timing
- Single conversion time: T = SAMPLE_CYCLES + HOLD_CYCLES + BITS·(1+DAC_SETTLE_CYCLES) + 1 (DONE).
- Latency from the clock edge that samples start_i=1 in IDLE to data_valid_o: (2^n)·T cycles. With defaults and n=0 this is 2675.
- busy_o rises the cycle after start is accepted. It falls in the cycle after DONE when the block returns to IDLE.
- dac_load_o: exactly BITS pulses per conversion, spaced 1+DAC_SETTLE_CYCLES apart.
- start_i while busy: ignored, not queued.

## Test plan
Bench parameters: BITS=4, SAMPLE_CYCLES=4, HOLD_CYCLES=2, DAC_SETTLE_CYCLES=3, CHANNELS=3. This gives T=23. Comparator model: comp_i = (vin ≥ dac_data_o).
- Single shot, vin=9, n=0:
  - Trial codes 8, 12, 10, 9.
  - data_o=9, data_ch_o=ch_i, data_valid_o exactly 23 cycles after start.
  - busy_o then falls, and there are no further dac_load_o pulses.
- Boundaries:
  - vin=15 gives trial codes 8, 12, 14, 15 and data_o=15.
  - vin=0 gives trial codes 8, 4, 2, 1 and data_o=0.
- Averaging, n=2, vin alternating 8, 9, 8, 9 per conversion:
  - One data_valid_o after 92 cycles, with data_o=8 (34>>2).
  - avg_log2_i=7 is clamped to AVG_MAX_LOG2.
- Continuous scan, scan_i=1, n=0, vin per channel {3, 7, 11}:
  - Results (ch, data) = (0,3), (1,7), (2,11), (0,3), spaced 23 cycles apart.
  - Clearing continuous_i mid-conversion yields exactly one more result, then IDLE.
- Reset mid-WAIT:
  - Assert reset_ni=0 asynchronously.
  - All outputs are 0 immediately, with no data_valid_o.
  - After release, a start produces a correct result.
- start_i pulsed while busy: no effect on the timing or the result of the conversion in progress.
